// File: rtl/ld_inc_counter.sv
// ld_inc_counter
//   Loadable up/down counter with fill-state tracking and overflow-attempt
//   accounting. Feeds the downstream counter-overflow assertion checker.
//
//   Build option: define LD_INC_COUNTER_WRAP_EN to make an overflow increment
//   wrap max -> 0. By default the counter saturates at max.
//
// Parameters
//   WIDTH      counter width (data_in / data_out)
//   ERR_CNT_W  width of the saturating overflow-attempt counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ld         load data_in (highest priority; inc/dec ignored)
//   inc        increment request
//   dec        decrement request (inc+dec together is a no-op)
//   data_in    load value
//   data_out   registered count
//   inc_rdy    an increment would be accepted without overflow
//   at_max     data_out == 2^WIDTH-1
//   at_zero    data_out == 0
//   ovf_pulse  one-cycle pulse for an inc request made while full
//   ovf_sticky set by an overflow attempt, cleared only by rst
//   ovf_count  overflow attempts, saturating at all-ones
module ld_inc_counter #(
  parameter int WIDTH     = 3,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld,
  input  logic                 inc,
  input  logic                 dec,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 inc_rdy,
  output logic                 at_max,
  output logic                 at_zero,
  output logic                 ovf_pulse,
  output logic                 ovf_sticky,
  output logic [ERR_CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    COUNTING = 2'd1,
    FULL     = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_req;

  // Next count and overflow detection. The fill state is re-derived from the
  // next count so loads can jump directly between any two states.
  always_comb begin
    ovf_req = inc && !dec && !ld && (state == FULL);
    cnt_nxt = data_out;
    if (ld) begin
      cnt_nxt = data_in;
    end else if (inc && !dec) begin
      if (state != FULL) begin
        cnt_nxt = data_out + 1'b1;
      end
`ifdef LD_INC_COUNTER_WRAP_EN
      else begin
        cnt_nxt = '0;
      end
`else
      // Saturate: an increment at max leaves the count unchanged.
`endif
    end else if (dec && !inc) begin
      // Underflow at zero is silently ignored.
      if (state != EMPTY) begin
        cnt_nxt = data_out - 1'b1;
      end
    end

    if (cnt_nxt == '0) begin
      state_nxt = EMPTY;
    end else if (cnt_nxt == CNT_MAX) begin
      state_nxt = FULL;
    end else begin
      state_nxt = COUNTING;
    end
  end

  // Status flags are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      state      <= EMPTY;
      inc_rdy    <= 1'b1;
      at_max     <= 1'b0;
      at_zero    <= 1'b1;
      ovf_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      data_out  <= cnt_nxt;
      state     <= state_nxt;
      inc_rdy   <= (state_nxt != FULL);
      at_max    <= (state_nxt == FULL);
      at_zero   <= (state_nxt == EMPTY);
      ovf_pulse <= ovf_req;
      if (ovf_req) begin
        ovf_sticky <= 1'b1;
      end
      if (ovf_req && (ovf_count != '1)) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ld_inc_counter.sv
// Testbench for ld_inc_counter: directed scenarios with literal expectations
// followed by randomized stimulus, all checked every cycle against a
// behavioural model of the counter.
module tb_ld_inc_counter;

  localparam int WIDTH     = 3;
  localparam int ERR_CNT_W = 4;
  localparam int MAXV      = (1 << WIDTH) - 1;
  localparam int ERRMAX    = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ld  = 1'b0;
  logic                 inc = 1'b0;
  logic                 dec = 1'b0;
  logic [WIDTH-1:0]     data_in = '0;
  logic [WIDTH-1:0]     data_out;
  logic                 inc_rdy;
  logic                 at_max;
  logic                 at_zero;
  logic                 ovf_pulse;
  logic                 ovf_sticky;
  logic [ERR_CNT_W-1:0] ovf_count;

  int checks = 0;
  int errors = 0;

  ld_inc_counter #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld),
    .inc        (inc),
    .dec        (dec),
    .data_in    (data_in),
    .data_out   (data_out),
    .inc_rdy    (inc_rdy),
    .at_max     (at_max),
    .at_zero    (at_zero),
    .ovf_pulse  (ovf_pulse),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: plain integer count plus overflow bookkeeping.
  int m_cnt    = 0;
  int m_ovf    = 0;
  bit m_pulse  = 0;
  bit m_sticky = 0;
  bit m_valid  = 0;

  always @(posedge clk) begin
    bit ov;
    if (rst) begin
      m_cnt = 0; m_ovf = 0; m_pulse = 0; m_sticky = 0; m_valid = 1;
    end else if (m_valid) begin
      ov = inc && !dec && !ld && (m_cnt == MAXV);
      m_pulse = ov;
      if (ld) m_cnt = int'(data_in);
      else if (inc && dec) m_cnt = m_cnt;
      else if (inc) begin
        if (m_cnt < MAXV) m_cnt = m_cnt + 1;
`ifdef LD_INC_COUNTER_WRAP_EN
        else m_cnt = 0;
`endif
      end else if (dec && m_cnt > 0) m_cnt = m_cnt - 1;
      if (ov) begin
        m_sticky = 1;
        if (m_ovf < ERRMAX) m_ovf = m_ovf + 1;
      end
    end
    #1;
    if (m_valid) begin
      chk("data_out",   int'(data_out),   m_cnt);
      chk("at_max",     int'(at_max),     int'(m_cnt == MAXV));
      chk("at_zero",    int'(at_zero),    int'(m_cnt == 0));
      chk("inc_rdy",    int'(inc_rdy),    int'(m_cnt != MAXV));
      chk("ovf_pulse",  int'(ovf_pulse),  int'(m_pulse));
      chk("ovf_sticky", int'(ovf_sticky), int'(m_sticky));
      chk("ovf_count",  int'(ovf_count),  m_ovf);
    end
  end

  // Apply one cycle of inputs at the falling edge; return just after the
  // rising edge that samples them.
  task automatic step(input bit r, input bit l, input bit i, input bit d,
                      input int din);
    @(negedge clk);
    rst = r; ld = l; inc = i; dec = d; data_in = WIDTH'(din);
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0);
    chk("rst data_out", int'(data_out), 0);
    chk("rst at_zero",  int'(at_zero), 1);
    chk("rst inc_rdy",  int'(inc_rdy), 1);
    chk("rst at_max",   int'(at_max), 0);
    chk("rst ovf_cnt",  int'(ovf_count), 0);

    // Count up to max
    for (int unsigned k = 1; k <= 7; k++) begin
      step(0, 0, 1, 0, 0);
      chk("inc step", int'(data_out), int'(k));
      chk("inc no ovf", int'(ovf_pulse), 0);
    end
    chk("full at_max",  int'(at_max), 1);
    chk("full inc_rdy", int'(inc_rdy), 0);

    // Overflow attempt
    step(0, 0, 1, 0, 0);
    chk("ovf pulse",  int'(ovf_pulse), 1);
    chk("ovf sticky", int'(ovf_sticky), 1);
    chk("ovf count",  int'(ovf_count), 1);
`ifdef LD_INC_COUNTER_WRAP_EN
    chk("ovf wrap",    int'(data_out), 0);
    chk("ovf at_zero", int'(at_zero), 1);
`else
    chk("ovf sat", int'(data_out), 7);
`endif
    step(0, 0, 0, 0, 0);
    chk("ovf one cycle", int'(ovf_pulse), 0);

    // Load beats increment at max
    step(0, 1, 0, 0, 7);
    step(0, 1, 1, 0, 5);
    chk("ld over inc", int'(data_out), 5);
    chk("ld no pulse", int'(ovf_pulse), 0);
    chk("ld cnt kept", int'(ovf_count), 1);

    // inc+dec cancel; dec at zero ignored
    step(0, 1, 0, 0, 3);
    step(0, 0, 1, 1, 0);
    chk("inc+dec hold", int'(data_out), 3);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("dec at 0", int'(data_out), 0);
    chk("dec at 0 zero", int'(at_zero), 1);
    chk("dec at 0 flag", int'(ovf_pulse), 0);

    // Load straight to full, then hold inc for 20 cycles
    step(0, 1, 0, 0, 7);
    chk("ld to full", int'(at_max), 1);
    for (int unsigned k = 0; k < 20; k++) begin
      step(0, 0, 1, 0, 0);
`ifndef LD_INC_COUNTER_WRAP_EN
      chk("hold pulse", int'(ovf_pulse), 1);
`endif
    end
`ifndef LD_INC_COUNTER_WRAP_EN
    chk("ovf saturate", int'(ovf_count), 15);
`endif

    // Reset mid-count with inc and sticky set
    step(0, 1, 0, 0, 4);
    step(1, 0, 1, 0, 0);
    chk("mid rst data", int'(data_out), 0);
    chk("mid rst sticky", int'(ovf_sticky), 0);
    chk("mid rst count", int'(ovf_count), 0);
    chk("mid rst rdy", int'(inc_rdy), 1);

    // Randomized traffic
    for (int unsigned k = 0; k < 3000; k++) begin
      bit r, l, i, d;
      int din;
      r   = ($urandom_range(0, 99) == 0);
      l   = ($urandom_range(0, 7) == 0);
      i   = ($urandom_range(0, 2) != 0);
      d   = ($urandom_range(0, 3) == 0);
      din = ($urandom_range(0, 3) == 0) ? MAXV : int'($urandom_range(0, MAXV));
      step(r, l, i, d, din);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
